// File: rtl/quadrature_generator.sv
// Quadrature A/B emulator: walks a Gray-coded (a,b) pair one edge at a time
// from the current position q toward a programmable target at a programmable rate.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | q == target (or no move requested); a/b held, timer idle
//   RUN   | timer counting down; on terminal count one edge toward target
module quadrature_generator #(
    parameter int POS_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    set_pos,
    input  logic [POS_WIDTH-1:0]    din,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    a,
    output logic                    b,
    output logic [POS_WIDTH-1:0]    q,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state, state_n;
    logic [1:0]              phase, phase_n;
    logic [POS_WIDTH-1:0]    q_n;
    logic [POS_WIDTH-1:0]    target, target_n;
    logic [PERIOD_WIDTH-1:0] timer, timer_n;
    logic                    done_n;
    logic                    a_n, b_n;

    logic [PERIOD_WIDTH-1:0] reload;
    logic [POS_WIDTH-1:0]    target_eff;

    // A period of zero behaves exactly like a period of one.
    assign reload = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);

    // A write landing on the stepping cycle steers that very step.
    assign target_eff = we ? din : target;

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        q_n      = q;
        target_n = target;
        timer_n  = timer;
        done_n   = 1'b0;

        if (set_pos) begin
            q_n      = din;
            target_n = din;
            timer_n  = '0;
            state_n  = IDLE;
            done_n   = (state == RUN);
        end else begin
            if (we) begin
                target_n = din;
            end
            unique case (state)
                IDLE: begin
                    if (we && (din != q)) begin
                        state_n = RUN;
                        timer_n = reload;
                    end
                end
                RUN: begin
                    if (timer != '0) begin
                        timer_n = timer - PERIOD_WIDTH'(1);
                    end else if (target_eff > q) begin
                        q_n     = q + POS_WIDTH'(1);
                        phase_n = phase + 2'd1;
                        timer_n = reload;
                        if (q_n == target_eff) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else if (target_eff < q) begin
                        q_n     = q - POS_WIDTH'(1);
                        phase_n = phase - 2'd1;
                        timer_n = reload;
                        if (q_n == target_eff) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Phase 0..3 maps to (a,b) = 00, 10, 11, 01.
    assign a_n = phase_n[1] ^ phase_n[0];
    assign b_n = phase_n[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            phase  <= 2'd0;
            a      <= 1'b0;
            b      <= 1'b0;
            q      <= '0;
            target <= '0;
            timer  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            a      <= a_n;
            b      <= b_n;
            q      <= q_n;
            target <= target_n;
            timer  <= timer_n;
            done   <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator: hand-computed edge timing, Gray
// sequence, retarget, set_pos override, and a small loopback decoder.
module tb_quadrature_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        set_pos = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] period = '0;
    logic        a, b, busy, done;
    logic [15:0] q;

    int vectors = 0;
    int miscompares = 0;

    quadrature_generator #(.POS_WIDTH(16), .PERIOD_WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .set_pos (set_pos),
        .din     (din),
        .period  (period),
        .a       (a),
        .b       (b),
        .q       (q),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Loopback decoder: classifies every a/b change seen at a clock edge.
    logic [1:0] ab_prev = 2'b00;
    int dec_fwd = 0;
    int dec_rev = 0;
    int dec_bad = 0;
    always @(posedge clk) begin
        if (rst_n && ({a, b} != ab_prev)) begin
            case ({ab_prev, a, b})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: dec_fwd = dec_fwd + 1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_rev = dec_rev + 1;
                default:                            dec_bad = dec_bad + 1;
            endcase
        end
        ab_prev = {a, b};
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ab, input logic [15:0] qv,
                           input logic bz, input logic dn);
        chk({tag, ".ab"}, {30'd0, a, b}, {30'd0, ab});
        chk({tag, ".q"}, {16'd0, q}, {16'd0, qv});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
    endtask

    task automatic wait_done(input string tag, input int limit);
        int i;
        i = 0;
        while (!done && i < limit) begin
            tick(1);
            i++;
        end
        chk({tag, ".done_seen"}, {31'd0, done}, 32'd1);
    endtask

    logic [1:0] fwd_ab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int fwd0, rev0;

    initial begin
        // Reset state
        #2;
        chk_out("reset", 2'b00, 16'd0, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Forward 0 -> 4, period 3
        we = 1'b1; din = 16'd4; period = 16'd3;
        tick(1);
        we = 1'b0;
        chk_out("fwd.accept", 2'b00, 16'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick(2);
            chk({"fwd.wait"}, {16'd0, q}, k - 1);
            tick(1);
            chk_out("fwd.edge", fwd_ab[k-1], 16'(k), (k != 4), (k == 4));
        end
        tick(1);
        chk_out("fwd.idle", 2'b00, 16'd4, 1'b0, 1'b0);

        // Reverse 4 -> 2, period 1
        we = 1'b1; din = 16'd2; period = 16'd1;
        tick(1);
        we = 1'b0;
        chk_out("rev.accept", 2'b00, 16'd4, 1'b1, 1'b0);
        tick(1);
        chk_out("rev.e1", 2'b01, 16'd3, 1'b1, 1'b0);
        tick(1);
        chk_out("rev.e2", 2'b11, 16'd2, 1'b0, 1'b1);
        tick(1);
        chk("rev.done_clear", {31'd0, done}, 32'd0);

        // period 0 behaves as period 1: 2 -> 5
        we = 1'b1; din = 16'd5; period = 16'd0;
        tick(1);
        we = 1'b0;
        tick(1);
        chk_out("p0.e1", 2'b01, 16'd3, 1'b1, 1'b0);
        tick(1);
        chk_out("p0.e2", 2'b00, 16'd4, 1'b1, 1'b0);
        tick(1);
        chk_out("p0.e3", 2'b10, 16'd5, 1'b0, 1'b1);
        tick(1);

        // set_pos while idle: no done, a/b unchanged
        set_pos = 1'b1; din = 16'd0;
        tick(1);
        set_pos = 1'b0;
        chk_out("setpos.idle", 2'b10, 16'd0, 1'b0, 1'b0);

        // Mid-run retarget: 0 -> 10 at period 5, retarget to 1 once q==3
        we = 1'b1; din = 16'd10; period = 16'd5;
        tick(1);
        we = 1'b0;
        tick(15);
        chk_out("rt.q3", 2'b00, 16'd3, 1'b1, 1'b0);
        we = 1'b1; din = 16'd1;
        tick(1);
        we = 1'b0;
        tick(3);
        chk_out("rt.hold", 2'b00, 16'd3, 1'b1, 1'b0);
        tick(1);
        chk_out("rt.r1", 2'b01, 16'd2, 1'b1, 1'b0);
        tick(4);
        chk("rt.wait", {16'd0, q}, 32'd2);
        tick(1);
        chk_out("rt.r2", 2'b11, 16'd1, 1'b0, 1'b1);
        tick(1);

        // set_pos overrides a simultaneous write during RUN
        we = 1'b1; din = 16'd10; period = 16'd2;
        tick(1);
        we = 1'b0;
        tick(2);
        chk_out("sp.step", 2'b01, 16'd2, 1'b1, 1'b0);
        we = 1'b1; set_pos = 1'b1; din = 16'd100;
        tick(1);
        we = 1'b0; set_pos = 1'b0;
        chk_out("sp.load", 2'b01, 16'd100, 1'b0, 1'b1);
        tick(6);
        chk_out("sp.quiet", 2'b01, 16'd100, 1'b0, 1'b0);

        // Loopback through the decoder at debounce-safe rates
        set_pos = 1'b1; din = 16'd0;
        tick(1);
        set_pos = 1'b0;
        tick(1);
        fwd0 = dec_fwd; rev0 = dec_rev;
        we = 1'b1; din = 16'd8; period = 16'd4096;
        tick(1);
        we = 1'b0;
        wait_done("lb.up", 40000);
        tick(2);
        chk("lb.up.q", {16'd0, q}, 32'd8);
        chk("lb.up.fwd", dec_fwd - fwd0, 32'd8);
        chk("lb.up.rev", dec_rev - rev0, 32'd0);
        fwd0 = dec_fwd; rev0 = dec_rev;
        we = 1'b1; din = 16'd0; period = 16'd2048;
        tick(1);
        we = 1'b0;
        wait_done("lb.down", 20000);
        tick(2);
        chk("lb.down.q", {16'd0, q}, 32'd0);
        chk("lb.down.rev", dec_rev - rev0, 32'd8);
        chk("lb.down.fwd", dec_fwd - fwd0, 32'd0);
        chk("lb.bad", dec_bad, 32'd0);

        // Asynchronous reset mid-run
        we = 1'b1; din = 16'd5; period = 16'd3;
        tick(1);
        we = 1'b0;
        tick(3);
        chk("ar.pre.q", {16'd0, q}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("ar.async", 2'b00, 16'd0, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk_out("ar.after", 2'b00, 16'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
